i2c_target_ctrl: RTL
====================

I2C_TARGET_CTRL -- requirements
Module: i2c_target_ctrl

Interface
REQ-001 The module SHALL have parameter REG_ADDR_BYTES, default 1, giving the number of register-pointer bytes per transaction (legal values 1 or 2).
REQ-002 The module SHALL have parameter NUM_REGS, default 16, giving the register count (1..2**(8*REG_ADDR_BYTES)).
REQ-003 The module SHALL have parameter WRAP_EN, default 1; 1 = pointer wraps to 0 after NUM_REGS-1, 0 = pointer saturates and further data bytes are NACKed.
REQ-004 The module SHALL have parameter GEN_CALL_EN, default 0; 1 = address 7'h00 with write is ACKed and treated as own address.
REQ-005 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Ports SHALL be, in order:
- clock  in  1  system clock
- reset_n  in  1  async active-low reset
- start_det  in  1  one-cycle pulse, START or repeated START seen
- stop_det  in  1  one-cycle pulse, STOP seen
- scl_rise  in  1  one-cycle pulse, SCL rising edge (sample point)
- scl_fall  in  1  one-cycle pulse, SCL falling edge (drive point)
- sda_in  in  1  synchronised SDA level
- dev_addr  in  7  own target address
- rd_data  in  8  register read data, combinational from reg_addr
- sda_oe  out  1  1 = pull SDA low
- reg_addr  out  AW  register pointer, AW = $clog2(NUM_REGS) (min 1)
- wr_en  out  1  one-cycle write strobe
- wr_data  out  8  write byte, valid with wr_en
- rd_strobe  out  1  one-cycle pulse when rd_data is captured
- busy  out  1  1 in any state other than IDLE
- addr_err  out  1  one-cycle pulse on NACKed pointer or data byte

Function
REQ-007 States SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
REQ-008 Priority SHALL be: reset_n low > stop_det (-> IDLE) > start_det (-> ADDR, bit counter 0) > edge-driven transitions; stop_det and start_det in the same cycle -> IDLE.
REQ-009 Bits SHALL be sampled MSB first from sda_in on scl_rise; the bit counter counts 0..7 and clears on each ACK-slot entry.
REQ-010 ADDR: after the 8th sample, the next scl_fall SHALL go to ADDR_ACK if byte[7:1]==dev_addr (or 0 with GEN_CALL_EN=1 and R/W=0), else IGNORE.
REQ-011 Each ACK slot SHALL assert sda_oe from the scl_fall entering it until the next scl_fall, then release.
REQ-012 ADDR_ACK exit: R/W=1 -> RD; R/W=0 -> PTR.
REQ-013 PTR SHALL receive REG_ADDR_BYTES bytes MSB-byte first, each ACKed in PTR_ACK; a complete pointer >= NUM_REGS SHALL be NACKed (sda_oe stays 0), pulse addr_err, and go to IGNORE; otherwise reg_addr loads and state goes to WR.
REQ-014 WR: on the 8th scl_rise, wr_en SHALL pulse one clock later with wr_data = received byte; WR_ACK ACKs, then reg_addr increments.
REQ-015 At reg_addr==NUM_REGS-1 the increment SHALL give 0 if WRAP_EN=1; if WRAP_EN=0 reg_addr holds and the next data byte gets no wr_en, is NACKed, pulses addr_err, and the state goes to IGNORE.
REQ-016 RD entry (from ADDR_ACK or RD_ACK on scl_fall) SHALL pulse rd_strobe and latch rd_data into the shift register; bit 7 is driven (sda_oe = ~bit) in the same cycle, and further bits on each following scl_fall.
REQ-017 RD: sda_oe SHALL be released on the scl_fall after bit 0, entering RD_ACK.
REQ-018 RD_ACK: the master ACK (sda_in=0 on scl_rise) SHALL increment reg_addr per REQ-015 and return to RD; a NACK SHALL go to IGNORE.
REQ-019 A repeated START after a write pointer SHALL keep reg_addr, so the following read starts at the written pointer.
REQ-020 IGNORE SHALL keep sda_oe=0 until start_det or stop_det.

Reset
REQ-021 On reset_n low, all outputs SHALL be 0: state IDLE, reg_addr 0, bit counter 0, shift register 0.

Structure
REQ-022 Package i2c_pkg SHALL hold the state enum and the ACK/NACK and R/W bit constants.
REQ-023 Sub-module i2c_byte_shifter SHALL hold the 8-bit shift register and the bit counter, with load, shift-in, shift-out and done signals.

Verification
REQ-024 Write 0xA0,0x03,0x5A,0x6B with dev_addr=7'h50 -> all four bytes ACKed; wr_en at reg 3 with 0x5A, then at reg 4 with 0x6B.
REQ-025 Write 0xA0,0x02, repeated START, 0xA1, master ACK then NACK (rd_data reg2=0x11, reg3=0x22) -> bytes 0x11 then 0x22 driven on SDA; IGNORE after the NACK.
REQ-026 Address 0xA2 (7'h51) -> no ACK; IGNORE; no wr_en or rd_strobe until STOP.
REQ-027 NUM_REGS=16, pointer 0x0F, data 0x01,0x02: WRAP_EN=1 -> writes to 15 then 0; WRAP_EN=0 -> second byte NACKed, addr_err pulses.
REQ-028 Pointer 0x20 with NUM_REGS=16 -> pointer NACKed, addr_err pulses, no wr_en.
REQ-029 reset_n low mid-byte in WR, or stop_det mid-byte -> IDLE immediately, sda_oe=0, no wr_en.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-target controller.
// Holds the FSM state encoding, bus bit meanings and pointer-width helper.
package i2c_pkg;

    localparam int BYTE_W = 8;

    // Bus level the receiver drives/sees in the ACK slot.
    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

    // Bit 0 of the address byte.
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WR       = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD       = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } state_t;

    function automatic int calc_aw(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/i2c_byte_shifter.sv
// Byte shift register with bit counter, used both to receive bytes on SCL rise
// and to serialise read data MSB first on SCL fall.
module i2c_byte_shifter
    import i2c_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_load_data,
    input  logic              i_shift_in,
    input  logic              i_bit,
    input  logic              i_shift_out,
    output logic [BYTE_W-1:0] o_data,
    output logic [2:0]        o_cnt,
    output logic              o_done
);

    logic [BYTE_W-1:0] r_data;
    logic [2:0]        r_cnt;
    logic              r_done;

    // Clear only resets the count; the data is kept so the FSM can still
    // inspect the byte that just completed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_load) begin
            r_data <= i_load_data;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_shift_in) begin
            r_data <= {r_data[BYTE_W-2:0], i_bit};
            r_cnt  <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_done <= 1'b1;
            end
        end else if (i_shift_out) begin
            r_data <= {r_data[BYTE_W-2:0], 1'b0};
            r_cnt  <= r_cnt + 3'd1;
        end
    end

    assign o_data = r_data;
    assign o_cnt  = r_cnt;
    assign o_done = r_done;

endmodule

// File: rtl/i2c_target_ctrl.sv
// I2C target protocol engine exposing a simple register-file interface:
// address match, register pointer, auto-incrementing writes and reads.
module i2c_target_ctrl
    import i2c_pkg::*;
#(
    parameter int  REG_ADDR_BYTES = 1,
    parameter int  NUM_REGS       = 16,
    parameter int  WRAP_EN        = 1,
    parameter int  GEN_CALL_EN    = 0,
    localparam int AW             = calc_aw(NUM_REGS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start_det,
    input  logic          stop_det,
    input  logic          scl_rise,
    input  logic          scl_fall,
    input  logic          sda_in,
    input  logic [6:0]    dev_addr,
    input  logic [7:0]    rd_data,
    output logic          sda_oe,
    output logic [AW-1:0] reg_addr,
    output logic          wr_en,
    output logic [7:0]    wr_data,
    output logic          rd_strobe,
    output logic          busy,
    output logic          addr_err
);

    localparam logic [AW-1:0] LAST_REG   = AW'(NUM_REGS - 1);
    localparam logic          LAST_IDX   = 1'(REG_ADDR_BYTES - 1);
    localparam logic [16:0]   NUM_REGS_W = 17'(NUM_REGS);

    state_t        r_state;
    logic          r_sda_oe;
    logic [AW-1:0] r_reg_addr;
    logic          r_wr_en;
    logic [7:0]    r_wr_data;
    logic          r_rd_strobe;
    logic          r_addr_err;
    logic          r_rw;
    logic          r_mack;
    logic          r_sat;
    logic          r_ptr_idx;
    logic [7:0]    r_ptr_hi;

    logic          w_clear;
    logic          w_load;
    logic          w_shift_in;
    logic          w_shift_out;
    logic [7:0]    w_sh_data;
    logic [2:0]    w_sh_cnt;
    logic          w_sh_done;

    logic          w_addr_match;
    logic [15:0]   w_ptr;
    logic          w_ptr_bad;
    logic          w_ptr_last;
    logic [7:0]    w_rx_byte;
    logic          w_at_last;
    logic [AW-1:0] w_inc_addr;
    logic          w_inc_sat;

    i2c_byte_shifter u_shifter (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_clear     (w_clear),
        .i_load      (w_load),
        .i_load_data (rd_data),
        .i_shift_in  (w_shift_in),
        .i_bit       (sda_in),
        .i_shift_out (w_shift_out),
        .o_data      (w_sh_data),
        .o_cnt       (w_sh_cnt),
        .o_done      (w_sh_done)
    );

    assign w_addr_match = (w_sh_data[7:1] == dev_addr) ||
                          ((GEN_CALL_EN != 0) && (w_sh_data[7:1] == 7'h00) &&
                           (w_sh_data[0] == RW_WRITE));
    assign w_ptr        = (REG_ADDR_BYTES == 2) ? {r_ptr_hi, w_sh_data} : {8'h00, w_sh_data};
    assign w_ptr_bad    = ({1'b0, w_ptr} >= NUM_REGS_W);
    assign w_ptr_last   = (r_ptr_idx == LAST_IDX);
    // Byte as it will stand after the sample taken this cycle.
    assign w_rx_byte    = {w_sh_data[6:0], sda_in};

    // Pointer advance: wrap to 0, or hold at the last register and flag saturation.
    assign w_at_last  = (r_reg_addr == LAST_REG);
    assign w_inc_addr = w_at_last ? ((WRAP_EN != 0) ? '0 : r_reg_addr) : (r_reg_addr + 1'b1);
    assign w_inc_sat  = w_at_last && (WRAP_EN == 0);

    always_comb begin
        w_clear     = 1'b0;
        w_load      = 1'b0;
        w_shift_in  = 1'b0;
        w_shift_out = 1'b0;
        if (start_det || stop_det) begin
            w_clear = 1'b1;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WR: begin
                    if (scl_rise && !w_sh_done) w_shift_in = 1'b1;
                    if (scl_fall && w_sh_done)  w_clear    = 1'b1;
                end
                ST_ADDR_ACK: begin
                    if (scl_fall && (r_rw == RW_READ)) w_load = 1'b1;
                end
                ST_RD: begin
                    if (scl_fall) begin
                        if (w_sh_cnt == 3'd7) w_clear     = 1'b1;
                        else                  w_shift_out = 1'b1;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_fall && r_mack) w_load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_sda_oe    <= 1'b0;
            r_reg_addr  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_rd_strobe <= 1'b0;
            r_addr_err  <= 1'b0;
            r_rw        <= 1'b0;
            r_mack      <= 1'b0;
            r_sat       <= 1'b0;
            r_ptr_idx   <= 1'b0;
            r_ptr_hi    <= '0;
        end else begin
            r_wr_en     <= 1'b0;
            r_rd_strobe <= 1'b0;
            r_addr_err  <= 1'b0;
            if (stop_det) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
            end else if (start_det) begin
                // reg_addr is deliberately kept so a repeated-START read follows a pointer write.
                r_state   <= ST_ADDR;
                r_sda_oe  <= 1'b0;
                r_mack    <= 1'b0;
                r_ptr_idx <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (scl_fall && w_sh_done) begin
                            r_rw <= w_sh_data[0];
                            if (w_addr_match) begin
                                r_state  <= ST_ADDR_ACK;
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (r_rw == RW_READ) begin
                                r_state     <= ST_RD;
                                r_rd_strobe <= 1'b1;
                                r_sda_oe    <= ~rd_data[7];
                            end else begin
                                r_state   <= ST_PTR;
                                r_sda_oe  <= 1'b0;
                                r_ptr_idx <= 1'b0;
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_fall && w_sh_done) begin
                            if (!w_ptr_last) begin
                                r_ptr_hi <= w_sh_data;
                                r_state  <= ST_PTR_ACK;
                                r_sda_oe <= 1'b1;
                            end else if (w_ptr_bad) begin
                                r_addr_err <= 1'b1;
                                r_state    <= ST_IGNORE;
                            end else begin
                                r_reg_addr <= w_ptr[AW-1:0];
                                r_sat      <= 1'b0;
                                r_state    <= ST_PTR_ACK;
                                r_sda_oe   <= 1'b1;
                            end
                        end
                    end
                    ST_PTR_ACK: begin
                        if (scl_fall) begin
                            r_sda_oe <= 1'b0;
                            if (w_ptr_last) begin
                                r_state <= ST_WR;
                            end else begin
                                r_ptr_idx <= 1'b1;
                                r_state   <= ST_PTR;
                            end
                        end
                    end
                    ST_WR: begin
                        if (scl_rise && (w_sh_cnt == 3'd7) && !w_sh_done && !r_sat) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= w_rx_byte;
                        end
                        if (scl_fall && w_sh_done) begin
                            if (r_sat) begin
                                r_addr_err <= 1'b1;
                                r_state    <= ST_IGNORE;
                            end else begin
                                r_state  <= ST_WR_ACK;
                                r_sda_oe <= 1'b1;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            r_sda_oe   <= 1'b0;
                            r_state    <= ST_WR;
                            r_reg_addr <= w_inc_addr;
                            r_sat      <= w_inc_sat;
                        end
                    end
                    ST_RD: begin
                        if (scl_fall) begin
                            if (w_sh_cnt == 3'd7) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_RD_ACK;
                                r_mack   <= 1'b0;
                            end else begin
                                r_sda_oe <= ~w_sh_data[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        // Advance on the ACK sample so rd_data is valid by the next fall.
                        if (scl_rise) begin
                            if (sda_in == ACK_BIT) begin
                                r_mack     <= 1'b1;
                                r_reg_addr <= w_inc_addr;
                                r_sat      <= w_inc_sat;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end else if (scl_fall && r_mack) begin
                            r_state     <= ST_RD;
                            r_rd_strobe <= 1'b1;
                            r_sda_oe    <= ~rd_data[7];
                            r_mack      <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_reg_addr;
    assign wr_en     = r_wr_en;
    assign wr_data   = r_wr_data;
    assign rd_strobe = r_rd_strobe;
    assign addr_err  = r_addr_err;
    assign busy      = (r_state != ST_IDLE);

endmodule
